// File: rtl/controller_responder.sv
// controller_responder: device side of the serial controller port. Acts as
// the 8-bit parallel-in/serial-out register of a standard pad, answering the
// console's latch/clock strobes on an active-low data line. Host strobes are
// asynchronous and are synchronized, edge-detected and registered before the
// FSM acts on them.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, no latch seen yet; data line released high
// LOAD  | latch high; snapshot follows buttons every cycle
// SHIFT | latch low; snapshot frozen, shifted on each console clock rise
// DONE  | 8 bits shifted; line held low, further clocks ignored

module controller_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_B,
    input  logic [7:0] buttons,
    input  logic       controller_latch,
    input  logic       controller_clk,
    output logic       controller_data_out_B,
    output logic       frame_start,
    output logic       frame_done,
    output logic [3:0] bit_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] cclk_sync;
    logic                   latch_hist;
    logic                   cclk_hist;
    logic                   latch_lvl;
    logic                   latch_fall;
    logic                   cclk_rise;
    logic [7:0]             shreg;
    state_t                 state;

    // Bring the asynchronous host strobes into the clk domain.
    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            latch_sync <= '0;
            cclk_sync  <= '0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], controller_latch};
            cclk_sync  <= {cclk_sync[SYNC_STAGES-2:0], controller_clk};
        end
    end

    // History flops plus registered level/edge events; the FSM only ever sees
    // these registered flags, so it never decodes a freshly synchronized bit.
    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            latch_hist <= 1'b0;
            cclk_hist  <= 1'b0;
            latch_lvl  <= 1'b0;
            latch_fall <= 1'b0;
            cclk_rise  <= 1'b0;
        end else begin
            latch_hist <= latch_sync[SYNC_STAGES-1];
            cclk_hist  <= cclk_sync[SYNC_STAGES-1];
            latch_lvl  <= latch_sync[SYNC_STAGES-1];
            latch_fall <= latch_hist & ~latch_sync[SYNC_STAGES-1];
            cclk_rise  <= cclk_sync[SYNC_STAGES-1] & ~cclk_hist;
        end
    end

    // Protocol FSM with registered outputs; a high latch overrides everything,
    // which also gives the latch edge priority over a coincident clock edge.
    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            state                 <= IDLE;
            shreg                 <= 8'h00;
            controller_data_out_B <= 1'b1;
            frame_start           <= 1'b0;
            frame_done            <= 1'b0;
            bit_index             <= 4'd0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            if (latch_lvl) begin
                state                 <= LOAD;
                shreg                 <= buttons;
                controller_data_out_B <= ~buttons[0];
                bit_index             <= 4'd0;
            end else begin
                case (state)
                    LOAD: begin
                        if (latch_fall) begin
                            state                 <= SHIFT;
                            frame_start           <= 1'b1;
                            controller_data_out_B <= ~shreg[0];
                            bit_index             <= 4'd0;
                        end
                    end
                    SHIFT: begin
                        if (cclk_rise) begin
                            // Fill with 1 so the bit reaching the output after
                            // the last shift reads as "pressed".
                            shreg                 <= {1'b1, shreg[7:1]};
                            controller_data_out_B <= ~shreg[1];
                            bit_index             <= bit_index + 4'd1;
                            if (bit_index == 4'd7) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
